dmem_lsu: RTL
=============

Name: dmem_lsu

Overview:
Load/store unit that initiates accesses on the core's synchronous data-memory port (address, write_data, we, mode; registered read_data one cycle later). It accepts one load/store at a time from the execute stage over a valid/ready handshake. It computes the effective address and checks funct3, alignment and range. It then sequences the memory access and returns a response (load data or error code) over a second valid/ready handshake to writeback.

Parameters:
BASE_ADDR, 32'h0000_0000, byte address of dmem word 0
DMEM_BYTES, 4096, dmem size in bytes; accesses with (ea - BASE_ADDR) >= DMEM_BYTES fault

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
req_valid  in  1  request present
req_ready  out  1  LSU can accept
req_store  in  1  1=store, 0=load
req_funct3  in  3  RV32I funct3 of the load/store
req_base  in  32  rs1 value
req_offset  in  32  sign-extended immediate
req_wdata  in  32  rs2 value (stores)
req_rd  in  5  destination register (loads)
rsp_valid  out  1  response present
rsp_ready  in  1  writeback accepts
rsp_data  out  32  extended load data; 0 for stores/errors
rsp_rd  out  5  echoed req_rd
rsp_is_load  out  1  echoed ~req_store
rsp_err  out  2  00 ok, 01 misaligned, 10 access fault, 11 illegal funct3
rsp_addr  out  32  effective address (for mtval)
mem_address  out  32  to dmem: ea - BASE_ADDR
mem_write_data  out  32  to dmem: req_wdata unmodified (dmem selects lanes)
mem_we  out  1  to dmem write enable
mem_mode  out  3  to dmem: `DM_* code from defines.vh
mem_read_data  in  32  from dmem, valid the cycle after address presented with we=0

Behaviour:
- States: IDLE, ACCESS, WAIT, RESP. Reset -> IDLE. Reset values: req_ready=1, rsp_valid=0, rsp_data=0, rsp_rd=0, rsp_is_load=0, rsp_err=00, rsp_addr=0, mem_address=0, mem_write_data=0, mem_mode=`DM_LW, mem_we=0.
- req_ready = (state==IDLE). Accept on the edge where req_valid&&req_ready. Latch ea = req_base+req_offset (mod 2^32), store flag, funct3, wdata, rd.
- Decode. Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW. Any other funct3 is illegal.
- Error check at accept, priority illegal > misaligned > fault. Misaligned: half with ea[0]=1, word with ea[1:0]!=0. Fault: (ea-BASE_ADDR) unsigned >= DMEM_BYTES.
- Error path: IDLE->RESP directly. No dmem access; mem_we never asserts. rsp_data=0.
- OK path: IDLE->ACCESS. mem_address, mem_mode, mem_write_data are registered at accept and held until the next accept.
- mem_we = (state==ACCESS) && store. It is combinational from state, so it is exactly one cycle wide.
- Store: ACCESS->RESP; dmem writes at the ACCESS-exit edge.
- Load: ACCESS->WAIT. On the WAIT-exit edge, capture mem_read_data into rsp_data, then go to RESP. Extension is done by dmem per mode and is not re-applied.
- RESP: rsp_valid=1. All rsp_* are stable while rsp_valid && !rsp_ready. On rsp_ready go to IDLE; rsp_valid drops the next cycle.
- Latency from accept edge to rsp_valid: error 1 cycle, store 2, load 3. The earliest next accept is the cycle after the response handshake (no overlap).
- Reset mid-operation (any state): at the reset edge go to IDLE, drop the pending op, rsp_valid=0. mem_we is 0 from that edge; no partial write is issued afterwards.
- While in IDLE, mem_we=0 and dmem may read freely; mem_read_data is ignored outside WAIT.
- ea wraps: base 32'hFFFF_FFFC + offset 8 gives 32'h0000_0004.

Test Plan:
1. SW base=0x100, off=0, wdata=0xDEADBEEF -> mem_we high exactly 1 cycle with mem_address=0x100 and `DM_SW; rsp_valid 2 cycles after accept, rsp_err=00. Then LW 0x100 -> rsp_data=0xDEADBEEF 3 cycles after accept.
2. SB 0x80 to ea 0x103, then LB 0x103 -> rsp_data=0xFFFFFF80; LBU 0x103 -> 0x00000080; LH 0x102 -> sign-extended upper half.
3. LW ea=0x102 -> rsp_err=01, rsp_addr=0x102, mem_we never asserted, rsp_valid 1 cycle after accept. funct3=011 -> rsp_err=11 (takes priority even if misaligned).
4. SW ea=0x1000 with DMEM_BYTES=4096 -> rsp_err=10, no write. Then LW 0x000 returns the unchanged contents.
5. Backpressure: hold rsp_ready=0 for 5 cycles -> rsp_* stable and req_ready=0 throughout. Raise rsp_ready -> next request accepted the following cycle.
6. Assert rst during ACCESS of a store -> mem_we=0 from the reset edge, state IDLE, rsp_valid=0, memory word unchanged.

Source files
------------

// File: rtl/dmem_lsu.sv
// rtl/dmem_lsu.sv - load/store unit sequencing one access on the synchronous data memory
//
// Accepts one load/store at a time from execute (req_*), computes the
// effective address, checks funct3/alignment/range, drives the dmem port
// (mem_*) and returns load data or an error code to writeback (rsp_*).
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   req_valid/req_ready            request handshake from execute
//   req_store, req_funct3          access kind and RV32I width/sign code
//   req_base, req_offset           rs1 and sign-extended immediate
//   req_wdata, req_rd              store data, load destination register
//   rsp_valid/rsp_ready            response handshake to writeback
//   rsp_data, rsp_rd, rsp_is_load  load result, echoed rd, echoed ~store
//   rsp_err, rsp_addr              error code and effective address
//   mem_address, mem_write_data    dmem byte address and raw store data
//   mem_we, mem_mode               dmem write enable and access mode
//   mem_read_data                  dmem registered read data

module dmem_lsu #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int unsigned DMEM_BYTES = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_base,
  input  logic [31:0] req_offset,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [4:0]  rsp_rd,
  output logic        rsp_is_load,
  output logic [1:0]  rsp_err,
  output logic [31:0] rsp_addr,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_we,
  output logic [2:0]  mem_mode,
  input  logic [31:0] mem_read_data
);

  // dmem mode codes share the funct3 encoding (LB=000 ... LHU=101, stores
  // use the byte/half/word codes), so funct3 is forwarded as the mode.
  localparam logic [2:0]  DM_LW      = 3'b010;
  localparam logic [31:0] DMEM_LIMIT = 32'(DMEM_BYTES);

  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_ALIGN = 2'b01;
  localparam logic [1:0] ERR_FAULT = 2'b10;
  localparam logic [1:0] ERR_ILL   = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_RESP} state_t;

  state_t      state_q, state_d;
  logic        store_q;
  logic [31:0] ea, ea_off;
  logic        illegal, misaligned, fault, accept;
  logic [1:0]  err_d;

  assign accept = req_valid && (state_q == S_IDLE);

  always_comb begin
    ea         = req_base + req_offset;
    ea_off     = ea - BASE_ADDR;
    // Loads allow 000,001,010,100,101; stores only 000,001,010.
    if (req_store) illegal = req_funct3[2] || (req_funct3[1:0] == 2'b11);
    else           illegal = (req_funct3[1:0] == 2'b11) || (req_funct3 == 3'b110);
    misaligned = ((req_funct3[1:0] == 2'b01) && ea[0]) ||
                 ((req_funct3[1:0] == 2'b10) && (ea[1:0] != 2'b00));
    fault      = (ea_off >= DMEM_LIMIT);
    if (illegal)         err_d = ERR_ILL;
    else if (misaligned) err_d = ERR_ALIGN;
    else if (fault)      err_d = ERR_FAULT;
    else                 err_d = ERR_OK;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (accept) state_d = (err_d != ERR_OK) ? S_RESP : S_ACCESS;
      S_ACCESS: state_d = store_q ? S_RESP : S_WAIT;
      S_WAIT:   state_d = S_RESP;
      S_RESP:   if (rsp_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  // Gated by rst so a reset landing on the ACCESS edge cannot commit a write.
  assign mem_we    = (state_q == S_ACCESS) && store_q && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      store_q        <= 1'b0;
      rsp_data       <= '0;
      rsp_rd         <= '0;
      rsp_is_load    <= 1'b0;
      rsp_err        <= ERR_OK;
      rsp_addr       <= '0;
      mem_address    <= '0;
      mem_write_data <= '0;
      mem_mode       <= DM_LW;
    end else begin
      state_q <= state_d;
      if (accept) begin
        store_q     <= req_store;
        rsp_data    <= '0;
        rsp_rd      <= req_rd;
        rsp_is_load <= ~req_store;
        rsp_err     <= err_d;
        rsp_addr    <= ea;
        // The dmem port only moves for accesses that will actually happen.
        if (err_d == ERR_OK) begin
          mem_address    <= ea_off;
          mem_write_data <= req_wdata;
          mem_mode       <= req_funct3;
        end
      end
      if (state_q == S_WAIT) rsp_data <= mem_read_data;
    end
  end

endmodule
